// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared widths, beat packing, arbiter states and ring arithmetic
// Beat packing is {id, addr, data} with id in the MSBs, matching the FIFO/register-slice path.
package axi_arb_pkg;
  localparam int ID_WIDTH = 3;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int AXI_LEN = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } axi_beat_t;
  typedef enum logic {ARB, LOCK} arb_state_e;
  function automatic int rr_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr (mod N)
// Ports: req request vector; ptr search start; gnt one-hot grant; idx grant index; any some req set.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  import axi_arb_pkg::*;
  // Scan offsets high to low so the closest requester to ptr is written last and wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[rr_add(int'(ptr), k, N)]) begin
        idx = IW'(rr_add(int'(ptr), k, N));
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N-to-1 round-robin arbiter with a single registered AXI-style output stage
// Ports: clk, rst (sync, active-high); in_AXI/svalid/sready per-requester beats;
//        out_AXI/dvalid/dready registered granted beat; out_src index of its requester.
// Define ARB_BURST_LOCK_EN to keep a grant for up to BURST_MAX consecutive beats.
module axi_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_WIDTH = axi_arb_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = axi_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_arb_pkg::DATA_WIDTH,
  parameter int BURST_MAX = 4,
  localparam int BEAT_W = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*BEAT_W-1:0] in_AXI,
  input  logic [N_REQ-1:0]        svalid,
  output logic [N_REQ-1:0]        sready,
  output logic [BEAT_W-1:0]       out_AXI,
  output logic                    dvalid,
  input  logic                    dready,
  output logic [IW-1:0]           out_src
);
  import axi_arb_pkg::*;
  if (N_REQ < 2 || N_REQ > 8 || BURST_MAX < 1) begin : g_cfg_err
    $error("axi_rr_arbiter: N_REQ must be 2..8 and BURST_MAX >= 1");
  end
  logic load_en, accept, any;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] gnt_idx, pick_ptr, ptr, ptr_nxt;
  assign load_en = !dvalid || dready;
  // rst gates the grant so nothing is offered while the output register is being cleared
  assign accept = any && load_en && !rst;
  assign sready = accept ? gnt : '0;
  rr_pick #(.N(N_REQ)) u_pick (
    .req(svalid),
    .ptr(pick_ptr),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(any)
  );
`ifdef ARB_BURST_LOCK_EN
  localparam int CW = $clog2(BURST_MAX + 1);
  arb_state_e state, state_nxt;
  logic [IW-1:0] lock_id, lock_id_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;
  logic lock_live;
  assign lock_live = (state == LOCK) && svalid[lock_id];
  // Starting the search at lock_id picks the owner if it is valid, otherwise falls through
  // to the normal rotation from lock_id+1 in the same cycle.
  assign pick_ptr = (state == LOCK) ? lock_id : ptr;
  always_comb begin
    state_nxt = state;
    lock_id_nxt = lock_id;
    beat_cnt_nxt = beat_cnt;
    ptr_nxt = ptr;
    if (lock_live && load_en) begin
      beat_cnt_nxt = beat_cnt + 1'b1;
      if (int'(beat_cnt) + 1 == BURST_MAX) begin
        state_nxt = ARB;
        beat_cnt_nxt = '0;
        ptr_nxt = IW'(rr_add(int'(lock_id), 1, N_REQ));
      end
    end else if (load_en) begin
      if (state == LOCK) begin
        state_nxt = ARB;
        beat_cnt_nxt = '0;
        ptr_nxt = IW'(rr_add(int'(lock_id), 1, N_REQ));
      end
      if (accept && BURST_MAX > 1) begin
        state_nxt = LOCK;
        lock_id_nxt = gnt_idx;
        beat_cnt_nxt = CW'(1);
      end else if (accept) begin
        ptr_nxt = IW'(rr_add(int'(gnt_idx), 1, N_REQ));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      lock_id <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      lock_id <= lock_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end
`else
  assign pick_ptr = ptr;
  assign ptr_nxt = accept ? IW'(rr_add(int'(gnt_idx), 1, N_REQ)) : ptr;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      dvalid <= 1'b0;
      out_AXI <= '0;
      out_src <= '0;
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (load_en) dvalid <= accept;
      if (accept) begin
        out_AXI <= in_AXI[int'(gnt_idx)*BEAT_W +: BEAT_W];
        out_src <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: randomized + directed scoreboard bench for axi_rr_arbiter
module tb_axi_rr_arbiter;
  import axi_arb_pkg::*;
  localparam int N = 4;
  localparam int BM = 4;
  localparam int AL = AXI_LEN;
`ifdef ARB_BURST_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif
  typedef struct {
    logic [AL-1:0] data;
    int src;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, dready = 1'b0;
  logic [N-1:0] svalid = '0, sready;
  logic [N*AL-1:0] in_axi = '0;
  logic [AL-1:0] out_axi;
  logic dvalid;
  logic [1:0] out_src;
  axi_beat_t pay [N];
  exp_t exp_q[$];
  int src_log[$];
  int errors = 0, checks = 0;
  int m_ptr = 0, m_owner = -1, m_cnt = 0, n_ptr, n_owner, n_cnt;
  bit m_dvalid = 1'b0, n_dvalid, m_zero = 1'b0, n_zero, started = 1'b0;
  logic [N-1:0] exp_sready = '0;
  int acc_cnt [N];

  always #5 clk = ~clk;

  axi_rr_arbiter #(.N_REQ(N), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                   .DATA_WIDTH(DATA_WIDTH), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .in_AXI(in_axi), .svalid(svalid), .sready(sready),
    .out_AXI(out_axi), .dvalid(dvalid), .dready(dready), .out_src(out_src)
  );

  function automatic void chk(input string name, input logic [AL-1:0] act, input logic [AL-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endfunction

  // Reference model: a requester owns a tenure of up to BM beats (lock build) or one beat;
  // the next search starts just after the last tenure owner.
  function automatic void decide();
    int g;
    int p;
    exp_t e;
    g = -1;
    n_ptr = m_ptr; n_owner = m_owner; n_cnt = m_cnt; n_dvalid = m_dvalid; n_zero = rst;
    exp_sready = '0;
    if (rst) begin
      n_ptr = 0; n_owner = -1; n_cnt = 0; n_dvalid = 1'b0;
    end else if (!m_dvalid || dready) begin
      p = m_ptr;
      if (m_owner >= 0 && svalid[m_owner]) g = m_owner;
      else begin
        if (m_owner >= 0) begin
          p = (m_owner + 1) % N; n_ptr = p; n_owner = -1; n_cnt = 0;
        end
        for (int k = 0; k < N; k++) if (g < 0 && svalid[(p + k) % N]) g = (p + k) % N;
      end
      n_dvalid = (g >= 0);
      if (g >= 0) begin
        exp_sready[g] = 1'b1;
        e.data = pay[g];
        e.src = g;
        exp_q.push_back(e);
        acc_cnt[g]++;
        if (LK && BM > 1) begin
          if (g == m_owner) begin
            n_cnt = m_cnt + 1;
            if (n_cnt == BM) begin
              n_owner = -1; n_cnt = 0; n_ptr = (g + 1) % N;
            end
          end else begin
            n_owner = g; n_cnt = 1;
          end
        end else n_ptr = (g + 1) % N;
      end
    end
  endfunction

  task automatic cycle(input bit r, input logic [N-1:0] sv, input bit dr);
    rst = r; svalid = sv; dready = dr;
    for (int i = 0; i < N; i++) in_axi[i*AL +: AL] = pay[i];
    decide();
    @(posedge clk);
    #1;
    m_ptr = n_ptr; m_owner = n_owner; m_cnt = n_cnt; m_dvalid = n_dvalid; m_zero = n_zero;
    started = 1'b1;
    if (r) exp_q.delete();
  endtask

  task automatic drain();
    repeat (2) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic check_log(input string name, input int want[$]);
    for (int k = 0; k < want.size(); k++)
      chk(name, AL'(k < src_log.size() ? src_log[k] : -1), AL'(want[k]));
  endtask

  function automatic axi_beat_t rand_beat();
    axi_beat_t b;
    b.id = ID_WIDTH'($urandom);
    b.addr = $urandom;
    b.data = $urandom;
    return b;
  endfunction

  always @(negedge clk) begin
    chk("sready", AL'(sready), AL'(exp_sready));
    if (started) begin
      chk("dvalid", AL'(dvalid), AL'(m_dvalid));
      if (m_zero) begin
        chk("reset out_AXI", out_axi, '0);
        chk("reset out_src", AL'(out_src), '0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started && dvalid && dready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: unexpected beat from %0d, none expected", out_src);
      end else begin
        e = exp_q.pop_front();
        chk("out_AXI", out_axi, e.data);
        chk("out_src", AL'(out_src), AL'(e.src));
        src_log.push_back(int'(out_src));
      end
    end
  end

  initial begin
    int want[$];
    logic [N-1:0] sv;
    #1;
    for (int i = 0; i < N; i++) begin
      pay[i] = '0;
      pay[i].data = DATA_WIDTH'(i + 1);
    end
    repeat (3) cycle(1'b1, '1, 1'b1);
    src_log.delete();
    repeat (8) cycle(1'b0, '1, 1'b1);
    repeat (2) cycle(1'b0, '1, 1'b0);
    repeat (6) cycle(1'b0, '1, 1'b1);
    drain();
    want.delete();
    for (int k = 0; k < 14; k++) want.push_back(LK ? (k / BM) % N : k % N);
    check_log("fairness src", want);
    cycle(1'b1, '0, 1'b0);
    src_log.delete();
    cycle(1'b0, 4'b0010, 1'b1);
    repeat (5) cycle(1'b0, 4'b1010, 1'b1);
    drain();
`ifdef ARB_BURST_LOCK_EN
    want = '{1, 1, 1, 1, 3, 3};
`else
    want = '{1, 3, 1, 3, 1, 3};
`endif
    check_log("sparse src", want);
`ifdef ARB_BURST_LOCK_EN
    cycle(1'b1, '0, 1'b0);
    src_log.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    for (int c = 0; c < 10; c++) begin
      sv = '1;
      if (acc_cnt[1] >= 2) sv[1] = 1'b0;
      cycle(1'b0, sv, 1'b1);
    end
    drain();
    want = '{0, 0, 0, 0, 1, 1, 2};
    check_log("lock drop src", want);
`endif
    cycle(1'b1, '0, 1'b0);
    repeat (3) cycle(1'b0, '1, 1'b1);
    cycle(1'b0, '1, 1'b0);
    cycle(1'b1, '1, 1'b0);
    src_log.delete();
    repeat (3) cycle(1'b0, '1, 1'b1);
    drain();
    want = '{0};
    check_log("restart src", want);
    sv = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!sv[i] || exp_sready[i]) begin
          sv[i] = ($urandom_range(0, 99) < 60);
          pay[i] = rand_beat();
        end
      cycle(1'b0, sv, $urandom_range(0, 99) < 70);
    end
    drain();
    chk("scoreboard empty", AL'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
